alu_bitserial_seq: RTL and testbench
====================================

Name: alu_bitserial_seq

Overview:
Bit-serial sequencer that runs a full WIDTH-bit ALU operation through the team's 1-bit ALU slice. It sits directly upstream of the slice and also consumes its outputs, closing the loop. It latches two operands and a 3-bit op select, then presents one bit pair per cycle, LSB first, and feeds the slice's carry/borrow back into its carry input. It assembles the WIDTH-bit result and reports carry, zero and completion with a start/busy/done handshake.

Parameters:
WIDTH, 16, operand/result width and number of serial bit cycles (>=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request to begin an operation; sampled only in IDLE
op_a  input  WIDTH  first operand, latched on accepted start
op_b  input  WIDTH  second operand, latched on accepted start
op_sel  input  3  operation code (slice encoding: 000 add, 001 sub, 010 mul/AND, 011 div, 100 AND, 101 OR, 110 XOR, 111 XNOR), latched on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse: result, carry_out and zero are valid
result  output  WIDTH  assembled result; held until the next accepted start
carry_out  output  1  final carry (add) or borrow (sub); 0 for all other ops
zero  output  1  result == 0; registered with result
slice_a  output  1  current bit of operand A to the slice
slice_b  output  1  current bit of operand B to the slice
slice_cin  output  1  carry/borrow into the slice
slice_sel  output  3  latched op code to the slice
slice_result  input  1  slice result bit (combinational from slice_* outputs)
slice_cout  input  1  slice carry/borrow out; valid only for op 000/001

Behaviour:
- States: IDLE, RUN, DONE. Bit counter is ceil(log2(WIDTH)) bits wide.
- Reset (rst=1 at an edge) has priority over everything and may occur mid-operation:
  - state goes to IDLE; busy=0, done=0, result=0, carry_out=0, zero=0.
  - Internal shift registers, counter, carry reg and latched sel are cleared to 0.
  - An aborted operation never produces done.
- IDLE with start=1 at edge e0:
  - latch op_a, op_b and op_sel; counter=0; carry reg=0; go to RUN.
  - result, carry_out and zero keep their old values until DONE.
- IDLE with start=0: stay in IDLE.
- RUN, cycle k (k=0..WIDTH-1):
  - slice_a=a_sh[0], slice_b=b_sh[0], slice_sel=sel_reg.
  - slice_cin=carry reg if sel_reg is 000 or 001, else 0.
  - At the edge: shift slice_result into the MSB of the result shift register (shift right), shift a_sh and b_sh right, and increment the counter.
  - If sel_reg is 000 or 001, carry reg <= slice_cout. Otherwise slice_cout is ignored and carry reg stays 0.
  - At the edge ending k=WIDTH-1: update result, carry_out (carry reg after the final bit) and zero, then go to DONE.
- Subtraction chains borrow: the slice computes a-b-cin, and its cout is the borrow. carry_out=1 means A<B unsigned.
- Ops 010 and 011 are per-bit, exactly as the slice defines them; no multi-bit multiply/divide.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE unconditionally. start in DONE is ignored.
- busy=1 exactly in RUN, i.e. WIDTH cycles, from the cycle after e0 through the edge e_WIDTH.
- done asserts in the cycle after e_WIDTH.
- Latency: start accepted at e0, done high after e_WIDTH; minimum start-to-start spacing is WIDTH+2 cycles.
- start during RUN or DONE is ignored with no effect. Operand/sel inputs are don't-care outside an accepted start.
- Outside RUN: slice_a=0, slice_b=0, slice_cin=0, slice_sel=sel_reg.
- All outputs except slice_a, slice_b and slice_cin are registered. slice_a and slice_b come straight from shift-register bit 0. slice_cin is a mux of the carry reg, gated by state and sel_reg.
- The bench instantiates the 1-bit slice and wires it to slice_*.

Test Plan:
- Add: op_a=0x1234, op_b=0x0FCD, op_sel=000 -> busy for 16 cycles, then done pulse; result=0x2201, carry_out=0, zero=0.
- Add overflow: 0xFFFF + 0x0001, op 000 -> result=0x0000, carry_out=1, zero=1.
- Sub with borrow: 0x0005 - 0x0007, op 001 -> result=0xFFFE, carry_out=1. Also 0x0007 - 0x0005 -> result=0x0002, carry_out=0.
- Logic: 0xAAAA XOR 0x5555, op 110 -> 0xFFFF, carry_out=0. 0xF0F0 XNOR 0xF0F0, op 111 -> 0xFFFF. Check slice_cin stays 0 throughout.
- Handshake:
  - start held high through RUN -> a second op starts only after DONE, and no second op is accepted in the DONE cycle.
  - start asserted in the DONE cycle and then dropped -> no new op.
  - start asserted one cycle after DONE -> new op accepted.
- Reset mid-op: assert rst at RUN bit 8 of an add -> next cycle busy=0, done=0, result=0, carry_out=0, zero=0. No done follows; a fresh start afterwards yields a correct result.

Source files
------------

// File: rtl/alu_bitserial_seq.sv
// Bit-serial ALU sequencer: streams two latched WIDTH-bit operands LSB first
// through an external 1-bit ALU slice. It chains the slice's carry/borrow for
// add/sub and assembles the result with carry and zero flags.
module alu_bitserial_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       op_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [2:0]       slice_sel,
  input  logic             slice_result,
  input  logic             slice_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic [2:0]       sel_q;

  // Only add (000) and sub (001) chain a carry/borrow between bits.
  logic             arith;
  logic             last_bit;
  logic [WIDTH-1:0] r_next;

  assign arith    = (sel_q[2:1] == 2'b00);
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign r_next   = {slice_result, r_sh[WIDTH-1:1]};

  // Operand shift registers shift in zeros, so bit 0 is already 0 outside RUN.
  assign slice_a   = a_sh[0];
  assign slice_b   = b_sh[0];
  assign slice_cin = (state == RUN && arith) ? carry_q : 1'b0;
  assign slice_sel = sel_q;

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      cnt       <= '0;
      carry_q   <= 1'b0;
      sel_q     <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh    <= op_a;
            b_sh    <= op_b;
            sel_q   <= op_sel;
            cnt     <= '0;
            carry_q <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          r_sh    <= r_next;
          a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
          cnt     <= cnt + 1'b1;
          carry_q <= arith ? slice_cout : 1'b0;
          if (last_bit) begin
            result    <= r_next;
            zero      <= (r_next == '0);
            carry_out <= arith ? slice_cout : 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // start is deliberately ignored here; a new op needs an IDLE cycle.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Bench for alu_bitserial_seq: models the 1-bit ALU slice in the loop, drives
// a table of operations plus handshake and reset corner cases, and scores
// results through an expected-value queue popped on each done pulse.
module tb_alu_bitserial_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [2:0]   op_sel = 3'b000;
  logic         busy, done, carry_out, zero;
  logic [W-1:0] result;
  logic         slice_a, slice_b, slice_cin, slice_result, slice_cout;
  logic [2:0]   slice_sel;

  int tests = 0;
  int fails = 0;

  alu_bitserial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .op_sel(op_sel), .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .zero(zero), .slice_a(slice_a),
    .slice_b(slice_b), .slice_cin(slice_cin), .slice_sel(slice_sel),
    .slice_result(slice_result), .slice_cout(slice_cout)
  );

  always #5 clk = ~clk;

  // 1-bit ALU slice; cout is deliberately junk for non-arithmetic ops.
  always_comb begin
    slice_result = 1'b0;
    slice_cout   = 1'b0;
    case (slice_sel)
      3'b000: begin
        slice_result = slice_a ^ slice_b ^ slice_cin;
        slice_cout   = (slice_a & slice_b) | (slice_cin & (slice_a ^ slice_b));
      end
      3'b001: begin
        slice_result = slice_a ^ slice_b ^ slice_cin;
        slice_cout   = (~slice_a & slice_b) | (~slice_a & slice_cin) | (slice_b & slice_cin);
      end
      3'b010: begin slice_result = slice_a & slice_b; slice_cout = 1'b1; end
      3'b011: begin slice_result = slice_b ? slice_a : 1'b1; slice_cout = 1'b1; end
      3'b100: begin slice_result = slice_a & slice_b; slice_cout = slice_a | slice_b; end
      3'b101: begin slice_result = slice_a | slice_b; slice_cout = slice_a | slice_b; end
      3'b110: begin slice_result = slice_a ^ slice_b; slice_cout = slice_a | slice_b; end
      default: begin slice_result = ~(slice_a ^ slice_b); slice_cout = slice_a | slice_b; end
    endcase
  end

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         z;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic [W-1:0] r;
    logic         c;
  } vec_t;

  exp_t sbq[$];
  logic cur_logic = 1'b0;
  int   busy_cnt = 0;
  logic cin_bad = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: count busy cycles, watch slice_cin, pop on done.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
      cin_bad  = 1'b0;
    end else begin
      if (busy) begin
        busy_cnt++;
        if (cur_logic && slice_cin) cin_bad = 1'b1;
      end
      if (done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("result", 32'(result), 32'(e.r));
          check("carry_out", 32'(carry_out), 32'(e.c));
          check("zero", 32'(zero), 32'(e.z));
          check("busy_cycles", busy_cnt, W);
          if (cur_logic) check("cin_zero", 32'(cin_bad), 32'd0);
        end
        busy_cnt = 0;
        cin_bad  = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] r, input logic c);
    exp_t e;
    e.r = r;
    e.c = c;
    e.z = (r == '0);
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel);
    op_a      = a;
    op_b      = b;
    op_sel    = sel;
    cur_logic = (sel[2:1] != 2'b00);
    start     = 1'b1;
  endtask

  // Wait until every expected result has been consumed; ends in the done cycle.
  task automatic wait_sb();
    for (int i = 0; i < 4 * W && sbq.size() != 0; i++) tick();
    if (sbq.size() != 0) begin
      check("timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel,
                        input logic [W-1:0] r, input logic c);
    drive(a, b, sel);
    push_exp(r, c);
    tick();
    start = 1'b0;
    wait_sb();
  endtask

  vec_t vecs[11];

  initial begin
    logic [W:0] m;
    logic [W-1:0] ra, rb;
    logic [2:0] rs;

    vecs[0]  = '{16'h1234, 16'h0FCD, 3'b000, 16'h2201, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 3'b000, 16'h0000, 1'b1};
    vecs[2]  = '{16'h0005, 16'h0007, 3'b001, 16'hFFFE, 1'b1};
    vecs[3]  = '{16'h0007, 16'h0005, 3'b001, 16'h0002, 1'b0};
    vecs[4]  = '{16'hAAAA, 16'h5555, 3'b110, 16'hFFFF, 1'b0};
    vecs[5]  = '{16'hF0F0, 16'hF0F0, 3'b111, 16'hFFFF, 1'b0};
    vecs[6]  = '{16'hF0F0, 16'h3C3C, 3'b100, 16'h3030, 1'b0};
    vecs[7]  = '{16'h1200, 16'h0034, 3'b101, 16'h1234, 1'b0};
    vecs[8]  = '{16'h00FF, 16'h0F0F, 3'b010, 16'h000F, 1'b0};
    vecs[9]  = '{16'h1234, 16'h1234, 3'b001, 16'h0000, 1'b0};
    vecs[10] = '{16'h5A5A, 16'h5A5A, 3'b110, 16'h0000, 1'b0};

    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_slice_bits", {29'd0, slice_a, slice_b, slice_cin}, 32'd0);
    check("rst_slice_sel", 32'(slice_sel), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].r, vecs[i].c);
      tick();
      check("done_pulse", {30'd0, done, busy}, 32'd0);
    end

    // Random add/sub against an arithmetic model
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = (i % 2 == 0) ? 3'b000 : 3'b001;
      m  = (rs == 3'b000) ? ({1'b0, ra} + {1'b0, rb}) : ({1'b0, ra} - {1'b0, rb});
      run_op(ra, rb, rs, m[W-1:0], m[W]);
      tick();
    end

    // start held high: second op only accepted after the DONE cycle
    drive(16'h0100, 16'h0023, 3'b000);
    push_exp(16'h0123, 1'b0);
    push_exp(16'h0123, 1'b0);
    for (int i = 0; i < W + 1; i++) tick();
    check("held_done", 32'(done), 32'd1);
    tick();
    check("held_idle_gap", {30'd0, busy, done}, 32'd0);
    tick();
    check("held_second_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_sb();
    tick();

    // start in DONE cycle only: ignored
    run_op(16'h0003, 16'h0004, 3'b000, 16'h0007, 1'b0);
    drive(16'h9999, 16'h1111, 3'b000);
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done_start_ignored", 32'(busy), 32'd0);
    end

    // start one cycle after DONE: accepted
    run_op(16'h0010, 16'h0001, 3'b001, 16'h000F, 1'b0);
    tick();
    drive(16'hFF00, 16'h00FF, 3'b101);
    push_exp(16'hFFFF, 1'b0);
    tick();
    start = 1'b0;
    check("after_done_accept", 32'(busy), 32'd1);
    wait_sb();
    tick();

    // Reset during bit 8 of an add
    run_op(16'h1234, 16'h0FCD, 3'b000, 16'h2201, 1'b0);
    tick();
    drive(16'h1111, 16'h2222, 3'b000);
    push_exp(16'h3333, 1'b0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    sbq.delete();
    tick();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_carry", 32'(carry_out), 32'd0);
    check("mid_rst_zero", 32'(zero), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < W + 4; i++) tick();
    run_op(16'h8000, 16'h8001, 3'b000, 16'h0001, 1'b1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
